// File: rtl/ring_counter_pkg.sv
// Shared constants and the pattern-advance function for the ring/Johnson counter.
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  // Widest counter the function supports; callers zero-extend into this.
  localparam int MAX_WIDTH = 32;

  // Advance a WIDTH-bit pattern (held in the low bits of state) by one step.
  // Ring mode feeds the outgoing end bit back unchanged, Johnson inverts it.
  function automatic logic [MAX_WIDTH-1:0] next_pattern(
    input logic [MAX_WIDTH-1:0] state,
    input logic                 mode,
    input logic                 dir,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] nxt;
    logic                 fb;
    nxt = {MAX_WIDTH{1'b0}};
    fb  = 1'b0;
    if (dir == DIR_LEFT) begin
      fb = state[width-1] ^ (mode == MODE_JOHNSON);
      for (int i = 0; i < MAX_WIDTH; i++) begin
        if (i == 0) begin
          nxt[i] = fb;
        end else if (i < width) begin
          nxt[i] = state[i-1];
        end else begin
          nxt[i] = 1'b0;
        end
      end
    end else begin
      fb = state[0] ^ (mode == MODE_JOHNSON);
      for (int i = 0; i < MAX_WIDTH; i++) begin
        if (i == width - 1) begin
          nxt[i] = fb;
        end else if (i < width - 1) begin
          nxt[i] = state[i+1];
        end else begin
          nxt[i] = 1'b0;
        end
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ring_step_prescaler.sv
// Step prescaler: qualifies one enabled cycle out of every PRESCALE.
// With PRESCALE=1 the count register never leaves zero and TICK reduces to EN.
module ring_step_prescaler
  import ring_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count_r;
  logic             at_last_s;

  // Terminal-count decode and step qualifier.
  always_comb begin
    at_last_s = (count_r == LAST);
    TICK      = EN & at_last_s;
  end

  // Prescale count: cleared by reset or load, frozen while EN is low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_r <= {CNT_W{1'b0}};
    end else if (CLR) begin
      count_r <= {CNT_W{1'b0}};
    end else if (EN) begin
      if (at_last_s) begin
        count_r <= {CNT_W{1'b0}};
      end else begin
        count_r <= count_r + CNT_W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/ring_counter_param.sv
// Parametrised ring/Johnson counter with prescaler, period-wrap pulse and
// all-zero ring lockup recovery. All outputs come straight from registers.
module ring_counter_param
  import ring_counter_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               PRESCALE = 1,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             MODE,
  input  logic             DIR,
  output logic [WIDTH-1:0] LED,
  output logic             WRAP,
  output logic             ERR
);

  localparam int CNT_W = $clog2(2 * WIDTH);
  localparam logic [CNT_W-1:0] RING_LAST    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] JOHNSON_LAST = CNT_W'(2 * WIDTH - 1);

  logic [WIDTH-1:0] led_r;
  logic             wrap_r;
  logic             err_r;
  logic [CNT_W-1:0] step_cnt_r;
  logic             mode_r;

  logic             tick_s;
  logic             step_s;
  logic             mode_chg_s;
  logic             zero_s;
  logic [CNT_W-1:0] last_s;
  logic [WIDTH-1:0] next_s;

  ring_step_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .CLR  (LOAD),
    .TICK (tick_s)
  );

  // Step qualification, mode-change detect, period end and next pattern.
  always_comb begin
    step_s     = tick_s & ~LOAD;
    mode_chg_s = (MODE != mode_r);
    zero_s     = (led_r == {WIDTH{1'b0}});
    if (MODE == MODE_JOHNSON) begin
      last_s = JOHNSON_LAST;
    end else begin
      last_s = RING_LAST;
    end
    next_s = WIDTH'(next_pattern(MAX_WIDTH'(led_r), MODE, DIR, WIDTH));
  end

  // Pattern, step count and pulse registers; RST over LOAD over step.
  always_ff @(posedge CLK) begin
    mode_r <= MODE;
    if (RST) begin
      led_r      <= SEED;
      wrap_r     <= 1'b0;
      err_r      <= 1'b0;
      step_cnt_r <= {CNT_W{1'b0}};
    end else if (LOAD) begin
      led_r      <= D;
      wrap_r     <= 1'b0;
      err_r      <= 1'b0;
      step_cnt_r <= {CNT_W{1'b0}};
    end else if (step_s) begin
      if ((MODE == MODE_RING) && zero_s) begin
        // Ring lockup: reseed, flag it, restart the period without a wrap.
        led_r      <= SEED;
        wrap_r     <= 1'b0;
        err_r      <= 1'b1;
        step_cnt_r <= {CNT_W{1'b0}};
      end else begin
        led_r <= next_s;
        err_r <= 1'b0;
        if (mode_chg_s) begin
          wrap_r     <= 1'b0;
          step_cnt_r <= {CNT_W{1'b0}};
        end else if (step_cnt_r == last_s) begin
          wrap_r     <= 1'b1;
          step_cnt_r <= {CNT_W{1'b0}};
        end else begin
          wrap_r     <= 1'b0;
          step_cnt_r <= step_cnt_r + CNT_W'(1);
        end
      end
    end else begin
      led_r  <= led_r;
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
      if (mode_chg_s) begin
        step_cnt_r <= {CNT_W{1'b0}};
      end else begin
        step_cnt_r <= step_cnt_r;
      end
    end
  end

  assign LED  = led_r;
  assign WRAP = wrap_r;
  assign ERR  = err_r;

endmodule

// File: tb/tb_ring_counter_param.sv
// Self-checking bench for ring_counter_param: directed scenarios against
// constant tables plus randomized traffic against a behavioural model.
module tb_ring_counter_param;

  localparam int         W    = 4;
  localparam logic [3:0] SEED = 4'b0001;

  logic       clk;
  logic       rst, en, load, mode, dir;
  logic [3:0] d;
  logic [3:0] led1, led3;
  logic       wrap1, wrap3, err1, err3;

  int tests_run = 0;
  int fails     = 0;

  // Behavioural model state, index 0 = PRESCALE 1 unit, index 1 = PRESCALE 3 unit.
  int m_led [2];
  int m_pc  [2];
  int m_sc  [2];
  bit m_mr  [2];
  bit m_wrap[2];
  bit m_err [2];
  int pre_of[2] = '{1, 3};

  ring_counter_param #(.WIDTH(W), .PRESCALE(1), .SEED(SEED)) dut1 (
    .CLK(clk), .RST(rst), .EN(en), .LOAD(load), .D(d), .MODE(mode), .DIR(dir),
    .LED(led1), .WRAP(wrap1), .ERR(err1)
  );

  ring_counter_param #(.WIDTH(W), .PRESCALE(3), .SEED(SEED)) dut3 (
    .CLK(clk), .RST(rst), .EN(en), .LOAD(load), .D(d), .MODE(mode), .DIR(dir),
    .LED(led3), .WRAP(wrap3), .ERR(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotation / twisted rotation as plain integer arithmetic.
  function automatic int shift_model(int x, bit md, bit dr);
    int mask, msb, lsb, fb;
    mask = (1 << W) - 1;
    msb  = (x >> (W - 1)) & 1;
    lsb  = x & 1;
    if (dr == 1'b0) begin
      fb = md ? (1 - msb) : msb;
      return ((x << 1) | fb) & mask;
    end else begin
      fb = md ? (1 - lsb) : lsb;
      return (x >> 1) | (fb << (W - 1));
    end
  endfunction

  task automatic model_cycle(int k);
    bit chg, step;
    int period;
    chg     = (mode != m_mr[k]);
    m_mr[k] = mode;
    period  = mode ? 2 * W : W;
    if (rst) begin
      m_led[k] = SEED; m_pc[k] = 0; m_sc[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
    end else if (load) begin
      m_led[k] = d; m_pc[k] = 0; m_sc[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
    end else begin
      m_wrap[k] = 0;
      m_err[k]  = 0;
      step = en && (m_pc[k] == pre_of[k] - 1);
      if (en) m_pc[k] = (m_pc[k] + 1) % pre_of[k];
      if (step && !mode && m_led[k] == 0) begin
        m_led[k] = SEED; m_err[k] = 1; m_sc[k] = 0;
      end else if (step) begin
        m_led[k] = shift_model(m_led[k], mode, dir);
        if (chg) m_sc[k] = 0;
        else begin
          m_sc[k] = m_sc[k] + 1;
          if (m_sc[k] == period) begin
            m_sc[k] = 0; m_wrap[k] = 1;
          end
        end
      end else if (chg) begin
        m_sc[k] = 0;
      end
    end
  endtask

  task automatic tick();
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; load = 0; d = 4'b1010; mode = 0; dir = 0;
    tick(); tick();
    rst = 0;
    tests_run++; if (led1 !== 4'b0001) begin fails++; $display("FAIL reset_led1 got %b expected 0001", led1); end
    tests_run++; if (wrap1 !== 1'b0 || err1 !== 1'b0) begin fails++; $display("FAIL reset_pulses got wrap=%b err=%b expected 0 0", wrap1, err1); end
    tests_run++; if (led3 !== 4'b0001) begin fails++; $display("FAIL reset_led3 got %b expected 0001", led3); end
  endtask

  task automatic test_ring_left();
    logic [3:0] exp_l [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1; tick();
    rst = 0; en = 1; mode = 0; dir = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++; if (led1 !== exp_l[i] || wrap1 !== (i == 3)) begin
        fails++; $display("FAIL ring_left step %0d got led=%b wrap=%b expected led=%b wrap=%b", i, led1, wrap1, exp_l[i], (i == 3));
      end
    end
  endtask

  task automatic test_johnson_left();
    logic [3:0] exp_j [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    load = 1; d = 4'b0000; mode = 1; en = 1; dir = 0;
    tick();
    load = 0;
    tests_run++; if (led1 !== 4'b0000) begin fails++; $display("FAIL johnson_load got %b expected 0000", led1); end
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++; if (led1 !== exp_j[i] || wrap1 !== (i == 7) || err1 !== 1'b0) begin
        fails++; $display("FAIL johnson_left step %0d got led=%b wrap=%b err=%b expected led=%b wrap=%b err=0", i, led1, wrap1, err1, exp_j[i], (i == 7));
      end
    end
  endtask

  task automatic test_self_start();
    load = 1; d = 4'b0000; mode = 0; en = 1; dir = 0;
    tick();
    load = 0;
    tick();
    tests_run++; if (led1 !== 4'b0001 || err1 !== 1'b1 || wrap1 !== 1'b0) begin
      fails++; $display("FAIL self_start got led=%b err=%b wrap=%b expected 0001 1 0", led1, err1, wrap1);
    end
    tick();
    tests_run++; if (led1 !== 4'b0010 || err1 !== 1'b0) begin
      fails++; $display("FAIL self_start_next got led=%b err=%b expected 0010 0", led1, err1);
    end
  endtask

  task automatic test_prescale();
    logic [3:0] exp_p [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    bit         en_p  [8] = '{1, 1, 1, 1, 0, 0, 1, 1};
    rst = 1; en = 0; load = 0; mode = 0; dir = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      en = en_p[i];
      tick();
      tests_run++; if (led3 !== exp_p[i]) begin
        fails++; $display("FAIL prescale cycle %0d got %b expected %b", i, led3, exp_p[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] exp_q [4] = '{4'b0101, 4'b1010, 4'b0101, 4'b1010};
    rst = 1; load = 1; d = 4'b1010; en = 1; mode = 0; dir = 0;
    tick();
    tests_run++; if (led1 !== 4'b0001) begin fails++; $display("FAIL prio_rst_load got %b expected 0001", led1); end
    rst = 0; load = 1; d = 4'b1010;
    tick();
    load = 0;
    tests_run++; if (led1 !== 4'b1010) begin fails++; $display("FAIL prio_load_step got %b expected 1010", led1); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++; if (led1 !== exp_q[i] || wrap1 !== (i == 3)) begin
        fails++; $display("FAIL prio_restart step %0d got led=%b wrap=%b expected led=%b wrap=%b", i, led1, wrap1, exp_q[i], (i == 3));
      end
    end
  endtask

  task automatic test_right_mode_switch();
    logic [3:0] exp_r [8] = '{4'b1010, 4'b1101, 4'b0110, 4'b1011, 4'b0101, 4'b0010, 4'b1001, 4'b0100};
    load = 1; d = 4'b0001; mode = 0; dir = 1; en = 1;
    tick();
    load = 0;
    tick();
    tests_run++; if (led1 !== 4'b1000) begin fails++; $display("FAIL ring_right_1 got %b expected 1000", led1); end
    tick();
    tests_run++; if (led1 !== 4'b0100) begin fails++; $display("FAIL ring_right_2 got %b expected 0100", led1); end
    en = 0; mode = 1;
    tick();
    tests_run++; if (led1 !== 4'b0100 || wrap1 !== 1'b0) begin fails++; $display("FAIL mode_switch_hold got led=%b wrap=%b expected 0100 0", led1, wrap1); end
    en = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++; if (led1 !== exp_r[i] || wrap1 !== (i == 7)) begin
        fails++; $display("FAIL johnson_right step %0d got led=%b wrap=%b expected led=%b wrap=%b", i, led1, wrap1, exp_r[i], (i == 7));
      end
    end
  endtask

  task automatic test_random();
    rst = 1; load = 0; en = 0; tick();
    rst = 0;
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 49) == 0);
      load = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 3) != 0);
      d    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) d = 4'b0000;
      dir  = 1'($urandom_range(0, 1));
      if ((!en || load || rst) && $urandom_range(0, 2) == 0) mode = ~mode;
      tick();
      tests_run++; if (led1 !== 4'(m_led[0]) || wrap1 !== m_wrap[0] || err1 !== m_err[0]) begin
        fails++; $display("FAIL random_p1 cycle %0d got led=%b wrap=%b err=%b expected led=%b wrap=%b err=%b", n, led1, wrap1, err1, 4'(m_led[0]), m_wrap[0], m_err[0]);
      end
      tests_run++; if (led3 !== 4'(m_led[1]) || wrap3 !== m_wrap[1] || err3 !== m_err[1]) begin
        fails++; $display("FAIL random_p3 cycle %0d got led=%b wrap=%b err=%b expected led=%b wrap=%b err=%b", n, led3, wrap3, err3, 4'(m_led[1]), m_wrap[1], m_err[1]);
      end
    end
  endtask

  initial begin
    rst = 1; en = 0; load = 0; d = 4'b0000; mode = 0; dir = 0;
    test_reset();
    test_ring_left();
    test_johnson_left();
    test_self_start();
    test_prescale();
    test_priority();
    test_right_mode_switch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/ring_counter_param.md
# ring_counter_param

Parametrised ring/Johnson counter for LED pattern and phase-sequence generation. It succeeds the fixed 4-bit ring counter and adds:
- configurable width;
- ring or Johnson (twisted-ring) mode;
- shift direction;
- a step prescaler;
- a period-wrap pulse;
- self-start recovery from the all-zero ring lockup.

It sits between the board clock domain and the LED/phase outputs; all outputs are registered.

## Interface
- WIDTH, 4: number of counter bits; legal range 2..32.
- PRESCALE, 1: enabled cycles per shift step; ≥1.
- SEED, 1 (WIDTH bits): value loaded by reset and by ring self-start.
- CLK  in  1  sole clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  count enable; when low, pattern and prescaler both freeze.
- LOAD  in  1  parallel load strobe, active-high.
- D  in  WIDTH  parallel load value.
- MODE  in  1  0 = ring, 1 = Johnson.
- DIR  in  1  0 = left (bit i → i+1), 1 = right (bit i → i−1).
- LED  out  WIDTH  current counter state.
- WRAP  out  1  one-cycle pulse on the step that completes a full period.
- ERR  out  1  one-cycle pulse when ring self-start fires.

## Operation
- Priority, highest first: RST, LOAD, step. At most one of these acts per cycle.
- Reset values: LED=SEED, WRAP=0, ERR=0, prescale count=0, step count=0.
- LOAD: LED←D; prescale and step counts cleared; WRAP=ERR=0. LOAD acts regardless of EN.
- A step occurs in a cycle with EN=1, LOAD=0, and prescale count = PRESCALE−1. The prescale count then wraps to 0; otherwise it increments while EN=1.
- Shift rules (W=WIDTH):
  - Ring left: {LED[W−2:0], LED[W−1]}.
  - Ring right: {LED[0], LED[W−1:1]}.
  - Johnson left: {LED[W−2:0], ~LED[W−1]}.
  - Johnson right: {~LED[0], LED[W−1:1]}.
- Ring self-start: when a step occurs in ring mode with LED all-zero, LED←SEED instead of the shift, and ERR pulses. No self-start in Johnson mode, because all-zero is a legal Johnson state.
- Period: W steps in ring mode, 2W steps in Johnson mode.
  - Step count increments on every step and wraps at period−1→0.
  - WRAP=1 in the cycle after the step that wraps the count, i.e. coincident with the new LED value.
  - A self-start step clears the step count and does not raise WRAP.
- MODE or DIR change:
  - Takes effect on the next step.
  - A MODE change, detected against a registered copy of MODE, clears the step count in that cycle; the prescale count is unaffected.
  - A DIR change does not clear the step count.
- PRESCALE=1: every enabled, non-load cycle is a step; the prescaler logic degenerates to a constant.

## Timing
- Latency: one cycle from step/LOAD/RST to LED. WRAP and ERR are registered and align with the LED update they describe.
- After RST deasserts with EN=1, the first step occurs PRESCALE cycles later.
- RST mid-period aborts immediately. No partial WRAP is emitted.
- EN low mid-prescale holds the prescale count. Counting resumes from the same count when EN returns high.
- WRAP and ERR are never high for more than one consecutive cycle unless consecutive steps each qualify. That is possible only with PRESCALE=1.

## Structure
- Package ring_counter_pkg holds:
  - MODE_RING=1'b0, MODE_JOHNSON=1'b1;
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1;
  - a function next_pattern(state, mode, dir) implementing the four shift rules.
- Sub-module ring_step_prescaler (params PRESCALE; ports CLK, RST, EN, CLR, TICK):
  - produces the step qualifier;
  - CLR is driven by LOAD.
- The top-level module holds the LED register, the step counter (width $clog2(2·WIDTH)), the registered MODE copy, and the WRAP/ERR registers.

## Test plan
All scenarios use WIDTH=4, SEED=4'b0001, PRESCALE=1 unless stated.

- Ring, left: RST, then EN=1, MODE=0, DIR=0 → LED sequence 0001, 0010, 0100, 1000, 0001. WRAP high only with the second 0001.
- Johnson, left: LOAD D=0000, then EN=1, MODE=1 → LED sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. WRAP high only with the final 0000.
- Ring self-start: LOAD D=0000, MODE=0, EN=1 → next cycle LED=0001 with ERR=1 for one cycle, WRAP=0. The following step gives LED=0010 with ERR=0.
- Prescale: PRESCALE=3, EN=1 → LED advances every 3rd cycle. Dropping EN for 2 cycles mid-count delays the next step by exactly 2 cycles.
- Priority: RST and LOAD (D=1010) in the same cycle → LED=0001. LOAD D=1010 on a step cycle → LED=1010, and the step count restarts from 0.
- Ring, right, with mode switch: DIR=1, MODE=0 from 0001 → 1000, 0100. Switching MODE to 1 mid-period clears the step count, so the next WRAP arrives 8 steps later.
